tm_master_reorder_receive: RTL

Receive-side companion to the multi-slave master traffic manager. It accepts replies that return from the NoC on up to four return VCs and buffers each VC separately. Replies are released to the master module in original request order, using a tag queue of return-VC numbers written at request-issue time. Each released reply pulses a per-VC credit return, which the send side uses to decrement its outstanding-request counters.

---
 rtl/tm_master_reorder_receive.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tm_master_reorder_receive.sv
// tm_master_reorder_receive: per-VC reply buffers released in request order via a VC tag queue.
// Define TM_REORDER_BYPASS_EN to let a head-VC reply skip its empty buffer and load the output register directly.
module tm_master_reorder_receive #(
    parameter int NUM_CREDITS      = 32,
    parameter int ORDER_DEPTH      = 32,
    parameter int VC_ADDRESS_WIDTH = 2,
    parameter int WIDTH_DATA       = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tag_valid_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] tag_vc_in,
    output logic                        tag_ready_out,
    input  logic                        rcv_valid_in,
    input  logic [WIDTH_DATA-1:0]       rcv_data_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] rcv_vc_in,
    output logic [3:0]                  rcv_ready_out,
    output logic                        rcv_valid_out,
    output logic [WIDTH_DATA-1:0]       rcv_data_out,
    input  logic                        rcv_ready_in,
    output logic [3:0]                  credit_return,
    output logic                        err_out
);
    localparam int NVC = 4;
    localparam int CW  = $clog2(NUM_CREDITS);
    localparam int OW  = $clog2(ORDER_DEPTH);

    logic [VC_ADDRESS_WIDTH-1:0] tag_mem [ORDER_DEPTH];
    logic [OW-1:0]               twr_q, twr_d, trd_q, trd_d;
    logic [OW:0]                 tcnt_q, tcnt_d;
    logic [WIDTH_DATA-1:0]       buf_mem [NVC][NUM_CREDITS];
    logic [CW-1:0]               bwr_q [NVC];
    logic [CW-1:0]               bwr_d [NVC];
    logic [CW-1:0]               brd_q [NVC];
    logic [CW-1:0]               brd_d [NVC];
    logic [CW:0]                 bcnt_q [NVC];
    logic [CW:0]                 bcnt_d [NVC];
    logic                        valid_q, valid_d;
    logic [WIDTH_DATA-1:0]       data_q, data_d;
    logic [3:0]                  credit_q, credit_d;
    logic                        err_q, err_d;
    logic                        tag_push, tag_empty, head_avail, out_free, byp, load, buf_wr, buf_rd;
    logic [NVC-1:0]              vc_wr, vc_rd;
    logic [VC_ADDRESS_WIDTH-1:0] head_vc;
    logic [WIDTH_DATA-1:0]       load_data;

    assign tag_ready_out = tcnt_q != (OW+1)'(ORDER_DEPTH);
    assign tag_empty     = tcnt_q == '0;
    assign tag_push      = tag_valid_in && tag_ready_out;
    assign head_vc       = tag_mem[trd_q];
    assign head_avail    = bcnt_q[head_vc] != '0;
    assign out_free      = !valid_q || rcv_ready_in;

`ifdef TM_REORDER_BYPASS_EN
    assign byp = rcv_valid_in && !tag_empty && !head_avail && out_free && rcv_vc_in == head_vc;
`else
    assign byp = 1'b0;
`endif

    // A load always consumes exactly one tag, whether the data came from a buffer or the bypass.
    assign load      = out_free && !tag_empty && (head_avail || byp);
    assign buf_rd    = load && !byp;
    assign buf_wr    = rcv_valid_in && rcv_ready_out[rcv_vc_in] && !byp;
    assign load_data = byp ? rcv_data_in : buf_mem[head_vc][brd_q[head_vc]];

    genvar v;
    for (v = 0; v < NVC; v++) begin : g_vc
        assign rcv_ready_out[v] = bcnt_q[v] != (CW+1)'(NUM_CREDITS);
        assign vc_wr[v]         = buf_wr && rcv_vc_in == VC_ADDRESS_WIDTH'(v);
        assign vc_rd[v]         = buf_rd && head_vc == VC_ADDRESS_WIDTH'(v);
    end

    always_comb begin
        twr_d  = tag_push ? twr_q + OW'(1) : twr_q;
        trd_d  = load ? trd_q + OW'(1) : trd_q;
        tcnt_d = tcnt_q + (OW+1)'(tag_push) - (OW+1)'(load);
        for (int i = 0; i < NVC; i++) begin
            bwr_d[i]  = vc_wr[i] ? bwr_q[i] + CW'(1) : bwr_q[i];
            brd_d[i]  = vc_rd[i] ? brd_q[i] + CW'(1) : brd_q[i];
            bcnt_d[i] = bcnt_q[i] + (CW+1)'(vc_wr[i]) - (CW+1)'(vc_rd[i]);
        end
        valid_d  = load || (valid_q && !rcv_ready_in);
        data_d   = load ? load_data : data_q;
        credit_d = load ? 4'b0001 << head_vc : 4'b0000;
        err_d    = err_q || (rcv_valid_in && !rcv_ready_out[rcv_vc_in]) || (tag_valid_in && !tag_ready_out);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            twr_q    <= '0;
            trd_q    <= '0;
            tcnt_q   <= '0;
            for (int i = 0; i < NVC; i++) begin
                bwr_q[i]  <= '0;
                brd_q[i]  <= '0;
                bcnt_q[i] <= '0;
            end
            valid_q  <= 1'b0;
            data_q   <= '0;
            credit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            twr_q    <= twr_d;
            trd_q    <= trd_d;
            tcnt_q   <= tcnt_d;
            for (int i = 0; i < NVC; i++) begin
                bwr_q[i]  <= bwr_d[i];
                brd_q[i]  <= brd_d[i];
                bcnt_q[i] <= bcnt_d[i];
            end
            valid_q  <= valid_d;
            data_q   <= data_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters alone define validity.
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[twr_q] <= tag_vc_in;
        if (buf_wr) buf_mem[rcv_vc_in][bwr_q[rcv_vc_in]] <= rcv_data_in;
    end

    assign rcv_valid_out = valid_q;
    assign rcv_data_out  = data_q;
    assign credit_return = credit_q;
    assign err_out       = err_q;
endmodule
